enemy_scheduler: RTL and testbench
==================================

ENEMY_SCHEDULER -- requirements
Module: enemy_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENEMY, default 4: number of enemies managed.
REQ-002 SHALL have parameter PLAYER_HP, default 100: player health after reset.
REQ-003 SHALL have parameter DAMAGE, default 10: health removed per granted attack.
REQ-004 SHALL have parameter ATTACK_COOLDOWN, default 30: frames between granted attacks.
REQ-005 SHALL have parameter RESPAWN_FRAMES, default 60: frames a killed enemy stays dead.
REQ-006 SHALL have port Clk  input  1  system clock, 50 MHz.
REQ-007 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port game_frame_clk_rising_edge  input  1  one-Clk frame tick pulse.
REQ-009 SHALL have port Enemy_Attack_Ready  input  NUM_ENEMY  per-enemy "in contact, wants to attack".
REQ-010 SHALL have port Enemy_Hit  input  NUM_ENEMY  per-enemy bullet hit, one-Clk pulse.
REQ-011 SHALL have port Enemy_Alive  output  NUM_ENEMY  per-enemy alive flag, drives enemy is_alive.
REQ-012 SHALL have port Attack_Grant  output  NUM_ENEMY  one-hot, one-Clk pulse: enemy whose attack landed.
REQ-013 SHALL have port Player_Health  output  8  current player health.
REQ-014 SHALL have port Kill_Count  output  8  enemies killed since reset.
REQ-015 SHALL have port Game_Over  output  1  high while in GAME_OVER state.

Function
REQ-016 SHALL implement two states: PLAY (after reset) and GAME_OVER; GAME_OVER exits only via Reset.
REQ-017 SHALL, in PLAY, clear Enemy_Alive[i] on the Clk after Enemy_Hit[i]=1 while Enemy_Alive[i]=1, on any cycle (not only frame ticks).
REQ-018 SHALL, on that kill, load respawn counter i with RESPAWN_FRAMES and increment Kill_Count, saturating at 255.
REQ-019 SHALL ignore Enemy_Hit[i] while Enemy_Alive[i]=0 (no count, no counter reload).
REQ-020 SHALL, on each frame tick, decrement every nonzero respawn counter; when a counter goes 1->0, set that Enemy_Alive bit on the same Clk edge.
REQ-021 SHALL keep a cooldown counter, loaded with 0 at reset, decremented on each frame tick, saturating at 0.
REQ-022 SHALL define eligible[i] = Enemy_Attack_Ready[i] & Enemy_Alive[i] & ~Enemy_Hit[i] (hit in the same cycle beats attack).
REQ-023 SHALL, on a frame tick in PLAY with cooldown==0 and any eligible bit set, grant the first eligible index searching circularly upward from round-robin pointer ptr.
REQ-024 SHALL register the grant: Attack_Grant one-hot for exactly one Clk following the deciding tick edge, zero otherwise.
REQ-025 SHALL, on a grant, reduce Player_Health by DAMAGE, saturating at 0, load cooldown with ATTACK_COOLDOWN, and set ptr = (granted index + 1) mod NUM_ENEMY.
REQ-026 SHALL keep ptr unchanged when no grant occurs.
REQ-027 SHALL enter GAME_OVER on the edge where Player_Health becomes 0; Game_Over registered high from that edge.
REQ-028 SHALL, in GAME_OVER, issue no grants, freeze Player_Health, Kill_Count, respawn counters and Enemy_Alive.
REQ-029 SHALL ignore all non-Reset inputs between frame ticks except Enemy_Hit.
REQ-030 SHALL size ptr as ceil(log2(NUM_ENEMY)) bits and counters wide enough for their parameters, without overflow.

Reset
REQ-031 SHALL, on Reset, set Enemy_Alive all-ones, Attack_Grant 0, Player_Health PLAYER_HP, Kill_Count 0, Game_Over 0, ptr 0, cooldown 0, respawn counters 0, state PLAY.
REQ-032 SHALL give Reset priority over every other input, including mid-cooldown, mid-respawn and in GAME_OVER.

Verification
REQ-033 SHALL verify: Ready=4'b1010 at first tick after reset -> Attack_Grant=4'b0010 one cycle, Health 90, ptr 2; next eligible tick 30 ticks later -> grant 4'b1000.
REQ-034 SHALL verify: Ready held 4'b1111 for 120 ticks -> grants every 30 ticks in order 0,1,2,3; Health 100->60; no grant on intermediate ticks.
REQ-035 SHALL verify: Enemy_Hit=4'b0100 single pulse -> Alive=4'b1011 next Clk, Kill_Count 1; Alive[2] returns on 60th tick; second hit while dead -> Kill_Count stays 1.
REQ-036 SHALL verify: Enemy_Hit[0] and Ready=4'b0001 on same tick with cooldown 0 -> no grant, Alive[0]=0, Health unchanged.
REQ-037 SHALL verify: Health 10 and grant -> Health 0, Game_Over=1; further Ready/Hit/ticks -> no grant, Kill_Count and Alive frozen; Reset -> all REQ-031 values.
REQ-038 SHALL verify: PLAYER_HP=15, DAMAGE=10 -> second grant saturates Health at 0, not 251.

Source files
------------

// File: rtl/enemy_scheduler.sv
// Enemy scheduler: grants enemy attacks round-robin on frame ticks, tracks
// kills/respawns and player health, and latches GAME_OVER when health runs out.
// Ports: Clk/Reset (sync, active-high); game_frame_clk_rising_edge frame tick;
//   Enemy_Attack_Ready/Enemy_Hit per-enemy inputs; Enemy_Alive, Attack_Grant
//   (registered one-hot pulse), Player_Health, Kill_Count, Game_Over outputs.
module enemy_scheduler #(
  parameter int NUM_ENEMY       = 4,
  parameter int PLAYER_HP       = 100,
  parameter int DAMAGE          = 10,
  parameter int ATTACK_COOLDOWN = 30,
  parameter int RESPAWN_FRAMES  = 60
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 game_frame_clk_rising_edge,
  input  logic [NUM_ENEMY-1:0] Enemy_Attack_Ready,
  input  logic [NUM_ENEMY-1:0] Enemy_Hit,
  output logic [NUM_ENEMY-1:0] Enemy_Alive,
  output logic [NUM_ENEMY-1:0] Attack_Grant,
  output logic [7:0]           Player_Health,
  output logic [7:0]           Kill_Count,
  output logic                 Game_Over
);

  localparam int PTR_W = (NUM_ENEMY > 1) ? $clog2(NUM_ENEMY) : 1;
  localparam int CD_W  = (ATTACK_COOLDOWN > 0) ? $clog2(ATTACK_COOLDOWN + 1) : 1;
  localparam int RS_W  = (RESPAWN_FRAMES > 0) ? $clog2(RESPAWN_FRAMES + 1) : 1;

  localparam logic [0:0] ST_PLAY = 1'b0;
  localparam logic [0:0] ST_OVER = 1'b1;

  logic [0:0]           state;
  logic [PTR_W-1:0]     ptr;
  logic [CD_W-1:0]      cooldown;
  logic [RS_W-1:0]      respawn_cnt [NUM_ENEMY];

  logic [NUM_ENEMY-1:0] eligible;
  logic [NUM_ENEMY-1:0] kill_vec;
  logic [NUM_ENEMY-1:0] grant_vec;
  logic                 grant_found;
  int                   grant_idx;
  int                   idx;
  int                   kill_sum;
  logic [7:0]           kill_next;
  logic [CD_W-1:0]      cd_dec;
  logic                 do_grant;
  logic [7:0]           health_dmg;
  logic [PTR_W-1:0]     ptr_next;

  // A hit in the same cycle wins over an attack from that enemy.
  assign eligible = Enemy_Attack_Ready & Enemy_Alive & ~Enemy_Hit;
  assign kill_vec = Enemy_Hit & Enemy_Alive;

  // Circular search upward from ptr for the first eligible enemy.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 0;
    idx         = 0;
    grant_vec   = '0;
    for (int k = 0; k < NUM_ENEMY; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_ENEMY) idx = idx - NUM_ENEMY;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
    if (grant_found) grant_vec[grant_idx] = 1'b1;
  end

  // Several enemies may die in the same cycle; count all of them.
  always_comb begin
    kill_sum = int'(Kill_Count);
    for (int i = 0; i < NUM_ENEMY; i++) kill_sum = kill_sum + int'(kill_vec[i]);
    kill_next = (kill_sum > 255) ? 8'd255 : 8'(kill_sum);
  end

  // The grant decision looks at the cooldown as decremented by this tick, so
  // a grant is followed by exactly ATTACK_COOLDOWN ticks until the next one.
  assign cd_dec     = (cooldown == '0) ? '0 : cooldown - CD_W'(1);
  assign do_grant   = (state == ST_PLAY) && game_frame_clk_rising_edge &&
                      (cd_dec == '0) && grant_found;
  assign health_dmg = (int'(Player_Health) <= DAMAGE) ? 8'd0
                                                      : Player_Health - 8'(DAMAGE);
  assign ptr_next   = PTR_W'((grant_idx + 1) % NUM_ENEMY);
  assign Game_Over  = (state == ST_OVER);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_PLAY;
      ptr           <= '0;
      cooldown      <= '0;
      Enemy_Alive   <= '1;
      Attack_Grant  <= '0;
      Player_Health <= 8'(PLAYER_HP);
      Kill_Count    <= 8'd0;
      for (int i = 0; i < NUM_ENEMY; i++) respawn_cnt[i] <= '0;
    end else if (state == ST_PLAY) begin
      Attack_Grant <= do_grant ? grant_vec : '0;
      Kill_Count   <= kill_next;
      if (game_frame_clk_rising_edge)
        cooldown <= do_grant ? CD_W'(ATTACK_COOLDOWN) : cd_dec;
      if (do_grant) begin
        Player_Health <= health_dmg;
        ptr           <= ptr_next;
        if (health_dmg == 8'd0) state <= ST_OVER;
      end
      for (int i = 0; i < NUM_ENEMY; i++) begin
        if (kill_vec[i]) begin
          Enemy_Alive[i] <= 1'b0;
          respawn_cnt[i] <= RS_W'(RESPAWN_FRAMES);
        end else if (game_frame_clk_rising_edge && respawn_cnt[i] != '0) begin
          respawn_cnt[i] <= respawn_cnt[i] - RS_W'(1);
          if (respawn_cnt[i] == RS_W'(1)) Enemy_Alive[i] <= 1'b1;
        end
      end
    end else begin
      // GAME_OVER: everything frozen except the grant pulse, which must end.
      Attack_Grant <= '0;
    end
  end

endmodule

// File: tb/tb_enemy_scheduler.sv
module tb_enemy_scheduler;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] ready = '0;
  logic [3:0] hit = '0;
  logic [3:0] alive, grant;
  logic [7:0] health, kills;
  logic       over;

  logic [3:0] ready2 = '0;
  logic [3:0] hit2 = '0;
  logic [3:0] alive2, grant2;
  logic [7:0] health2, kills2;
  logic       over2;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  enemy_scheduler u_dut (
    .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(tick),
    .Enemy_Attack_Ready(ready), .Enemy_Hit(hit),
    .Enemy_Alive(alive), .Attack_Grant(grant), .Player_Health(health),
    .Kill_Count(kills), .Game_Over(over)
  );

  enemy_scheduler #(.PLAYER_HP(15), .DAMAGE(10)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(tick),
    .Enemy_Attack_Ready(ready2), .Enemy_Hit(hit2),
    .Enemy_Alive(alive2), .Attack_Grant(grant2), .Player_Health(health2),
    .Kill_Count(kills2), .Game_Over(over2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step(input logic t);
    tick = t;
    @(posedge Clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    ready = '0; hit = '0; ready2 = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    int         pre;
    logic [3:0] rdy;
    logic [3:0] hit;
    logic       tk;
    logic [3:0] exp_grant;
    logic [7:0] exp_hp;
    logic [3:0] exp_alive;
    logic [7:0] exp_kill;
    logic       exp_over;
  } vec_t;

  vec_t vecs [11];

  initial begin
    //          rst pre rdy      hit      tk  grant    hp     alive    kill  over
    vecs[0]  = '{1, 0,  4'b1010, 4'b0000, 1, 4'b0010, 8'd90, 4'b1111, 8'd0, 0};
    vecs[1]  = '{0, 29, 4'b1010, 4'b0000, 1, 4'b1000, 8'd80, 4'b1111, 8'd0, 0};
    vecs[2]  = '{1, 0,  4'b1111, 4'b0000, 1, 4'b0001, 8'd90, 4'b1111, 8'd0, 0};
    vecs[3]  = '{0, 29, 4'b1111, 4'b0000, 1, 4'b0010, 8'd80, 4'b1111, 8'd0, 0};
    vecs[4]  = '{0, 29, 4'b1111, 4'b0000, 1, 4'b0100, 8'd70, 4'b1111, 8'd0, 0};
    vecs[5]  = '{0, 29, 4'b1111, 4'b0000, 1, 4'b1000, 8'd60, 4'b1111, 8'd0, 0};
    // kill between ticks, respawn on the 60th tick, re-hit while dead ignored
    vecs[6]  = '{0, 0,  4'b0000, 4'b0100, 0, 4'b0000, 8'd60, 4'b1011, 8'd1, 0};
    vecs[7]  = '{0, 58, 4'b0000, 4'b0100, 1, 4'b0000, 8'd60, 4'b1011, 8'd1, 0};
    vecs[8]  = '{0, 0,  4'b0000, 4'b0000, 1, 4'b0000, 8'd60, 4'b1111, 8'd1, 0};
    // hit beats attack in the same cycle; then ptr still 0, enemy 0 dead
    vecs[9]  = '{0, 0,  4'b0001, 4'b0001, 1, 4'b0000, 8'd60, 4'b1110, 8'd2, 0};
    vecs[10] = '{0, 0,  4'b0011, 4'b0000, 1, 4'b0010, 8'd50, 4'b1110, 8'd2, 0};

    do_reset();
    chk("rst_alive", alive, 4'b1111);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_health", health, 8'd100);
    chk("rst_kills", kills, 8'd0);
    chk("rst_over", over, 1'b0);

    for (int v = 0; v < 11; v++) begin
      logic any_idle_grant;
      if (vecs[v].rst) do_reset();
      any_idle_grant = 1'b0;
      for (int p = 0; p < vecs[v].pre; p++) begin
        ready = vecs[v].rdy; hit = '0;
        step(1'b1);
        if (grant !== 4'b0000) any_idle_grant = 1'b1;
      end
      if (vecs[v].pre > 0) chk($sformatf("v%0d_idle_grant", v), any_idle_grant, 1'b0);
      ready = vecs[v].rdy; hit = vecs[v].hit;
      step(vecs[v].tk);
      hit = '0;
      chk($sformatf("v%0d_grant", v), grant, vecs[v].exp_grant);
      chk($sformatf("v%0d_health", v), health, vecs[v].exp_hp);
      chk($sformatf("v%0d_alive", v), alive, vecs[v].exp_alive);
      chk($sformatf("v%0d_kills", v), kills, vecs[v].exp_kill);
      chk($sformatf("v%0d_over", v), over, vecs[v].exp_over);
      // grant is a single-Clk pulse
      step(1'b0);
      chk($sformatf("v%0d_grant_end", v), grant, 4'b0000);
    end

    // Drain health to zero: ten grants, rotating 0,1,2,3,...
    do_reset();
    ready = 4'b1111;
    for (int g = 0; g < 10; g++) begin
      logic [3:0] eg;
      eg = 4'b0001 << (g % 4);
      if (g > 0) repeat (29) step(1'b1);
      step(1'b1);
      chk($sformatf("go_grant%0d", g), grant, eg);
      chk($sformatf("go_health%0d", g), health, 8'(100 - 10 * (g + 1)));
    end
    chk("go_over", over, 1'b1);
    begin
      logic any_grant;
      any_grant = 1'b0;
      hit = 4'b1111;
      for (int t = 0; t < 40; t++) begin
        step(1'b1);
        if (grant !== 4'b0000) any_grant = 1'b1;
      end
      hit = '0;
      chk("go_frozen_grant", any_grant, 1'b0);
    end
    chk("go_frozen_alive", alive, 4'b1111);
    chk("go_frozen_kills", kills, 8'd0);
    chk("go_frozen_health", health, 8'd0);
    chk("go_still_over", over, 1'b1);

    do_reset();
    chk("go_rst_alive", alive, 4'b1111);
    chk("go_rst_grant", grant, 4'b0000);
    chk("go_rst_health", health, 8'd100);
    chk("go_rst_kills", kills, 8'd0);
    chk("go_rst_over", over, 1'b0);
    // ptr and cooldown back at 0: immediate grant to enemy 0
    ready = 4'b1111;
    step(1'b1);
    chk("go_rst_first_grant", grant, 4'b0001);
    ready = '0;

    // Reset mid-cooldown and mid-respawn
    hit = 4'b0010;
    step(1'b0);
    hit = '0;
    repeat (5) step(1'b1);
    do_reset();
    chk("mid_rst_alive", alive, 4'b1111);
    ready = 4'b0100;
    step(1'b1);
    chk("mid_rst_grant", grant, 4'b0100);
    chk("mid_rst_health", health, 8'd90);

    // Saturating damage on the small-HP instance
    do_reset();
    ready2 = 4'b0001;
    step(1'b1);
    chk("sat_grant1", grant2, 4'b0001);
    chk("sat_health1", health2, 8'd5);
    chk("sat_over1", over2, 1'b0);
    repeat (29) step(1'b1);
    step(1'b1);
    chk("sat_grant2", grant2, 4'b0001);
    chk("sat_health2", health2, 8'd0);
    chk("sat_over2", over2, 1'b1);
    ready2 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
